unidade_load_store: RTL and testbench
=====================================

// Module: unidade_load_store
// PURPOSE
//  Load/store unit between the EX stage and the word-addressed data memory.
//  - Converts CPU byte-address requests (LW/LH/LHU/LB/LBU/SW/SH/SB) into word accesses.
//  - Performs read-modify-write for sub-word stores.
//  - Sign/zero-extends sub-word loads.
//  - Flags misaligned, reserved-size and out-of-range accesses.
//  - Holds ocupado high while a request is in flight; the pipeline stalls on it.
// PARAMETERS
//  MEM_SIZE  150  number of 32-bit words in data memory; word addr >= MEM_SIZE is an error
//  ADDR_W    26   data memory word-address width
// PORTS
//  clock             in   1         system clock, rising edge
//  reset             in   1         synchronous, active-high
//  req_valid         in   1         request present; sampled only in OCIOSO
//  req_escrita       in   1         1 = store, 0 = load
//  req_tamanho       in   2         00 byte, 01 halfword, 10 word, 11 reserved
//  req_sinal         in   1         1 = sign-extend sub-word load (ignored for stores/word)
//  req_endereco      in   ADDR_W+2  byte address; [1:0] = byte offset
//  req_dado          in   32        store data; byte/half taken from LSBs
//  pronto            out  1         one-cycle pulse: request finished (with or without erro)
//  ocupado           out  1         high in every state except OCIOSO
//  erro              out  1         valid with pronto; 1 = access suppressed
//  dado_lido         out  32        extended load result; held until next completed load
//  mem_endereco      out  ADDR_W    word address to data memory
//  mem_memWrite      out  1         write strobe to data memory
//  mem_dado_escrito  out  32        write data to data memory
//  mem_dado_lido     in   32        combinational read data from data memory
// BEHAVIOUR
//  Reset values: state=OCIOSO, pronto=0, ocupado=0, erro=0, dado_lido=0, mem_memWrite=0,
//   mem_endereco=0, mem_dado_escrito=0.
//  Reset mid-operation: return to OCIOSO next edge; any pending write is dropped; memory untouched.
//  FSM states: OCIOSO, LER, ESCREVER, FIM.
//  Accept (OCIOSO & req_valid): latch escrita/tamanho/sinal/endereco/dado, then branch:
//   - error: tamanho==11, or half with addr[0]!=0, or word with addr[1:0]!=0,
//     or word addr >= MEM_SIZE -> FIM, erro=1, no memory access.
//   - load -> LER -> FIM (pronto 2 cycles after accept edge).
//   - store word -> ESCREVER -> FIM.
//   - store byte/half -> LER -> ESCREVER -> FIM.
//  LER: mem_endereco = latched addr[ADDR_W+1:2]; capture mem_dado_lido into buffer at the edge.
//  ESCREVER: mem_memWrite=1 for exactly this cycle.
//   mem_dado_escrito = latched word, or buffer with the selected lane replaced.
//  FIM: pronto=1 for one cycle. Load: dado_lido updated at the FIM entry edge. Next state OCIOSO.
//  Outside LER/ESCREVER: mem_memWrite=0, mem_endereco holds last value.
//  Little-endian lanes:
//   - byte off k -> bits[8k+7:8k].
//   - half off 0 -> [15:0]; half off 2 -> [31:16].
//  Load extension:
//   - req_sinal=1: replicate MSB of the lane.
//   - req_sinal=0: zero-fill.
//  erro is only meaningful while pronto=1; it is 0 otherwise.
//  req_valid while ocupado: ignored (not queued); the caller holds the request until pronto.
//  Minimum spacing: a new request is accepted in the cycle after FIM.
// STRUCTURE
//  Shared package pacote_lsu:
//   - size encodings TAM_BYTE/TAM_HALF/TAM_WORD.
//   - FSM state encodings.
//  Sub-module alinhador_subpalavra (combinational):
//   - extract+extend a lane from a word.
//   - merge a byte/half into a word by offset.
//  Top: FSM, request latches, read buffer, dado_lido register.
// TESTING
//  1 Word store at 0x10 (=word 4), data 0xDEADBEEF, then LW 0x10
//    -> one mem_memWrite pulse, word 4 written; LW gives dado_lido=0xDEADBEEF, erro=0.
//  2 Word 4=0x11223344; SB 0x12 data 0xAA
//    -> sequence LER, ESCREVER; word 4 becomes 0x11AA3344, pronto exactly 3 cycles after accept.
//  3 Word 4=0x8000F0FF; LB 0x10 sinal=1 -> 0xFFFFFFFF;
//    LBU 0x11 -> 0x000000F0; LH 0x12 sinal=1 -> 0xFFFF8000.
//  4 LW 0x12, SH 0x13, tamanho=11, LW 0x258 (word 150)
//    -> each: pronto 1 cycle after accept, erro=1, mem_memWrite never asserted.
//  5 req_valid held during ocupado with a changed address -> second request not accepted until
//    after pronto; the first completes with its original address.
//  6 Assert reset during ESCREVER of an SB -> mem_memWrite 0 from next edge, target word
//    unchanged, all outputs at reset values, OCIOSO.

Source files
------------

// File: rtl/unidade_load_store_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used when a request is accepted.
package pacote_lsu;

  typedef enum logic [1:0] {
    TAM_BYTE = 2'b00,
    TAM_HALF = 2'b01,
    TAM_WORD = 2'b10,
    TAM_RESV = 2'b11
  } tamanho_e;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    LER      = 2'b01,
    ESCREVER = 2'b10,
    FIM      = 2'b11
  } estado_e;

  // True when the size/offset pair cannot be served (reserved size included).
  function automatic logic desalinhado(input tamanho_e tam, input logic [1:0] off);
    logic r;
    case (tam)
      TAM_BYTE: r = 1'b0;
      TAM_HALF: r = off[0];
      TAM_WORD: r = (off != 2'b00);
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unidade_load_store_alinhador.sv
// Combinational lane handling for sub-word accesses (little-endian):
// extracts and extends a lane for loads, merges store data into a word.
module alinhador_subpalavra
  import pacote_lsu::*;
(
  input  logic [31:0] palavra_i,
  input  logic [1:0]  offset_i,
  input  tamanho_e    tamanho_i,
  input  logic        sinal_i,
  input  logic [31:0] dado_i,
  output logic [31:0] extraido_o,
  output logic [31:0] mesclado_o
);

  logic [7:0]  byte_s;
  logic [15:0] meia_s;

  // Select the addressed lane and extend it to 32 bits for the load path.
  always_comb begin
    byte_s = 8'h00;
    meia_s = 16'h0000;
    case (offset_i)
      2'd0:    byte_s = palavra_i[7:0];
      2'd1:    byte_s = palavra_i[15:8];
      2'd2:    byte_s = palavra_i[23:16];
      2'd3:    byte_s = palavra_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset_i[1]) begin
      meia_s = palavra_i[31:16];
    end else begin
      meia_s = palavra_i[15:0];
    end
    case (tamanho_i)
      TAM_BYTE: extraido_o = {{24{sinal_i & byte_s[7]}}, byte_s};
      TAM_HALF: extraido_o = {{16{sinal_i & meia_s[15]}}, meia_s};
      TAM_WORD: extraido_o = palavra_i;
      default:  extraido_o = palavra_i;
    endcase
  end

  // Replace the addressed lane of the read word with the store data LSBs.
  always_comb begin
    mesclado_o = palavra_i;
    case (tamanho_i)
      TAM_BYTE: begin
        case (offset_i)
          2'd0:    mesclado_o[7:0]   = dado_i[7:0];
          2'd1:    mesclado_o[15:8]  = dado_i[7:0];
          2'd2:    mesclado_o[23:16] = dado_i[7:0];
          2'd3:    mesclado_o[31:24] = dado_i[7:0];
          default: mesclado_o = palavra_i;
        endcase
      end
      TAM_HALF: begin
        if (offset_i[1]) begin
          mesclado_o[31:16] = dado_i[15:0];
        end else begin
          mesclado_o[15:0] = dado_i[15:0];
        end
      end
      TAM_WORD: mesclado_o = dado_i;
      default:  mesclado_o = palavra_i;
    endcase
  end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit between EX and a word-addressed data memory.
// Byte-address requests become word accesses; sub-word stores use a
// read-modify-write; misaligned, reserved-size and out-of-range requests
// complete with erro and never touch memory.
module unidade_load_store
  import pacote_lsu::*;
#(
  parameter int MEM_SIZE = 150,
  parameter int ADDR_W   = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_escrita,
  input  logic [1:0]        req_tamanho,
  input  logic              req_sinal,
  input  logic [ADDR_W+1:0] req_endereco,
  input  logic [31:0]       req_dado,
  output logic              pronto,
  output logic              ocupado,
  output logic              erro,
  output logic [31:0]       dado_lido,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_memWrite,
  output logic [31:0]       mem_dado_escrito,
  input  logic [31:0]       mem_dado_lido
);

  localparam logic [ADDR_W-1:0] MEM_LIMITE = ADDR_W'(MEM_SIZE);

  estado_e           estado_q, estado_d;
  logic              escrita_q, escrita_d;
  tamanho_e          tamanho_q, tamanho_d;
  logic              sinal_q, sinal_d;
  logic [1:0]        offset_q, offset_d;
  logic [31:0]       dado_q, dado_d;
  logic [ADDR_W-1:0] mem_endereco_q, mem_endereco_d;
  logic [31:0]       mem_dado_escrito_q, mem_dado_escrito_d;
  logic              mem_memWrite_q, mem_memWrite_d;
  logic              pronto_q, pronto_d;
  logic              ocupado_q, ocupado_d;
  logic              erro_q, erro_d;
  logic [31:0]       dado_lido_q, dado_lido_d;

  tamanho_e          tamanho_req_s;
  logic [ADDR_W-1:0] palavra_req_s;
  logic              erro_req_s;
  logic [31:0]       extraido_s;
  logic [31:0]       mesclado_s;

  assign tamanho_req_s = tamanho_e'(req_tamanho);
  assign palavra_req_s = req_endereco[ADDR_W+1:2];
  assign erro_req_s    = desalinhado(tamanho_req_s, req_endereco[1:0]) ||
                         (palavra_req_s >= MEM_LIMITE);

  alinhador_subpalavra u_alinhador (
    .palavra_i  (mem_dado_lido),
    .offset_i   (offset_q),
    .tamanho_i  (tamanho_q),
    .sinal_i    (sinal_q),
    .dado_i     (dado_q),
    .extraido_o (extraido_s),
    .mesclado_o (mesclado_s)
  );

  // Next state plus next values of the registered outputs, derived from the state being entered.
  always_comb begin
    estado_d           = estado_q;
    escrita_d          = escrita_q;
    tamanho_d          = tamanho_q;
    sinal_d            = sinal_q;
    offset_d           = offset_q;
    dado_d             = dado_q;
    mem_endereco_d     = mem_endereco_q;
    mem_dado_escrito_d = mem_dado_escrito_q;
    mem_memWrite_d     = 1'b0;
    erro_d             = 1'b0;
    dado_lido_d        = dado_lido_q;
    case (estado_q)
      OCIOSO: begin
        if (req_valid) begin
          escrita_d = req_escrita;
          tamanho_d = tamanho_req_s;
          sinal_d   = req_sinal;
          offset_d  = req_endereco[1:0];
          dado_d    = req_dado;
          if (erro_req_s) begin
            // Suppressed access: memory address and data keep their last values.
            estado_d = FIM;
            erro_d   = 1'b1;
          end else if (!req_escrita) begin
            estado_d       = LER;
            mem_endereco_d = palavra_req_s;
          end else if (tamanho_req_s == TAM_WORD) begin
            estado_d           = ESCREVER;
            mem_endereco_d     = palavra_req_s;
            mem_dado_escrito_d = req_dado;
            mem_memWrite_d     = 1'b1;
          end else begin
            estado_d       = LER;
            mem_endereco_d = palavra_req_s;
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      LER: begin
        if (escrita_q) begin
          // The read word is merged on the fly and held as the write buffer.
          estado_d           = ESCREVER;
          mem_dado_escrito_d = mesclado_s;
          mem_memWrite_d     = 1'b1;
        end else begin
          estado_d    = FIM;
          dado_lido_d = extraido_s;
        end
      end
      ESCREVER: estado_d = FIM;
      FIM:      estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
    pronto_d  = (estado_d == FIM);
    ocupado_d = (estado_d != OCIOSO);
  end

  // State, request latches and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q           <= OCIOSO;
      escrita_q          <= 1'b0;
      tamanho_q          <= TAM_BYTE;
      sinal_q            <= 1'b0;
      offset_q           <= 2'b00;
      dado_q             <= 32'h0000_0000;
      mem_endereco_q     <= '0;
      mem_dado_escrito_q <= 32'h0000_0000;
      mem_memWrite_q     <= 1'b0;
      pronto_q           <= 1'b0;
      ocupado_q          <= 1'b0;
      erro_q             <= 1'b0;
      dado_lido_q        <= 32'h0000_0000;
    end else begin
      estado_q           <= estado_d;
      escrita_q          <= escrita_d;
      tamanho_q          <= tamanho_d;
      sinal_q            <= sinal_d;
      offset_q           <= offset_d;
      dado_q             <= dado_d;
      mem_endereco_q     <= mem_endereco_d;
      mem_dado_escrito_q <= mem_dado_escrito_d;
      mem_memWrite_q     <= mem_memWrite_d;
      pronto_q           <= pronto_d;
      ocupado_q          <= ocupado_d;
      erro_q             <= erro_d;
      dado_lido_q        <= dado_lido_d;
    end
  end

  // A reset raised during the write cycle cancels the strobe before the memory edge.
  assign mem_memWrite     = mem_memWrite_q & ~reset;
  assign mem_endereco     = mem_endereco_q;
  assign mem_dado_escrito = mem_dado_escrito_q;
  assign pronto           = pronto_q;
  assign ocupado          = ocupado_q;
  assign erro             = erro_q;
  assign dado_lido        = dado_lido_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// Self-checking bench for unidade_load_store: directed scenarios followed by
// random requests checked against a behavioural memory/extension model.
module tb_unidade_load_store;

  localparam int MEM_SIZE = 150;
  localparam int ADDR_W   = 26;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid, req_escrita, req_sinal;
  logic [1:0]        req_tamanho;
  logic [ADDR_W+1:0] req_endereco;
  logic [31:0]       req_dado;
  logic              pronto, ocupado, erro, mem_memWrite;
  logic [31:0]       dado_lido, mem_dado_escrito, mem_dado_lido;
  logic [ADDR_W-1:0] mem_endereco;

  logic [31:0] mem [0:MEM_SIZE-1] = '{default: 32'h0};
  logic [31:0] ref_mem [0:MEM_SIZE-1];
  int          wr_total = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_dl;

  unidade_load_store #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_escrita(req_escrita),
    .req_tamanho(req_tamanho), .req_sinal(req_sinal), .req_endereco(req_endereco),
    .req_dado(req_dado), .pronto(pronto), .ocupado(ocupado), .erro(erro),
    .dado_lido(dado_lido), .mem_endereco(mem_endereco), .mem_memWrite(mem_memWrite),
    .mem_dado_escrito(mem_dado_escrito), .mem_dado_lido(mem_dado_lido)
  );

  always #5 clock = ~clock;

  assign mem_dado_lido = (mem_endereco < 26'd150) ? mem[mem_endereco[7:0]] : 32'h0;

  always @(posedge clock) begin
    if (mem_memWrite) begin
      if (mem_endereco < 26'd150) mem[mem_endereco[7:0]] <= mem_dado_escrito;
      wr_total <= wr_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] tam,
                                           input logic sg, input logic [1:0] off);
    logic [31:0] v;
    if (tam == 2'd2) return w;
    if (tam == 2'd0) begin
      v = (w >> (8 * int'(off))) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (8 * int'(off))) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] tam,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    if (tam == 2'd2) return d;
    mask = ((tam == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * int'(off));
    return (w & ~mask) | ((d << (8 * int'(off))) & mask);
  endfunction

  // Called at the first negedge after the accept edge; returns cycles to pronto (0 = timeout).
  task automatic wait_pronto(output int lat);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clock);
      if (pronto === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic wr, input logic [1:0] tam,
                         input logic sg, input logic [25:0] word, input logic [1:0] off,
                         input logic [31:0] data);
    logic err;
    int   exp_lat, lat, w0;
    err = (tam == 2'd3) || (tam == 2'd1 && off[0]) || (tam == 2'd2 && off != 2'd0) ||
          (word >= 26'd150);
    exp_lat = err ? 1 : (!wr ? 2 : (tam == 2'd2 ? 2 : 3));
    if (!err) begin
      if (wr) ref_mem[word[7:0]] = ref_store(ref_mem[word[7:0]], tam, off, data);
      else    exp_dl = ref_load(ref_mem[word[7:0]], tam, sg, off);
    end
    w0 = wr_total;
    req_valid = 1'b1; req_escrita = wr; req_tamanho = tam; req_sinal = sg;
    req_endereco = {word, off}; req_dado = data;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    wait_pronto(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_erro"}, {31'd0, erro}, {31'd0, err});
    check({tag, "_dado_lido"}, dado_lido, exp_dl);
    @(negedge clock);
    check({tag, "_pulso"}, {30'd0, pronto, erro}, 32'd0);
    check({tag, "_escritas"}, 32'(wr_total - w0), (wr && !err) ? 32'd1 : 32'd0);
    if (word < 26'd150) check({tag, "_mem"}, mem[word[7:0]], ref_mem[word[7:0]]);
  endtask

  initial begin
    int lat, w0;
    logic [1:0] tam, off;
    logic [25:0] word;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 32'h0;
    exp_dl = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_escrita = 1'b0; req_tamanho = 2'd0;
    req_sinal = 1'b0; req_endereco = '0; req_dado = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_saidas", {28'd0, pronto, ocupado, erro, mem_memWrite}, 32'd0);
    check("reset_dado_lido", dado_lido, 32'h0);
    check("reset_mem_end", 32'(mem_endereco), 32'h0);
    check("reset_mem_dado", mem_dado_escrito, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // 1: word store then word load
    run_req("t1_sw", 1'b1, 2'd2, 1'b0, 26'd4, 2'd0, 32'hDEADBEEF);
    run_req("t1_lw", 1'b0, 2'd2, 1'b0, 26'd4, 2'd0, 32'h0);
    check("t1_lw_const", dado_lido, 32'hDEADBEEF);

    // 2: read-modify-write byte store
    run_req("t2_sw", 1'b1, 2'd2, 1'b0, 26'd4, 2'd0, 32'h11223344);
    run_req("t2_sb", 1'b1, 2'd0, 1'b0, 26'd4, 2'd2, 32'h000000AA);
    check("t2_sb_const", mem[4], 32'h11AA3344);

    // 3: sub-word load extension
    run_req("t3_sw", 1'b1, 2'd2, 1'b0, 26'd4, 2'd0, 32'h8000F0FF);
    run_req("t3_lb", 1'b0, 2'd0, 1'b1, 26'd4, 2'd0, 32'h0);
    check("t3_lb_const", dado_lido, 32'hFFFFFFFF);
    run_req("t3_lbu", 1'b0, 2'd0, 1'b0, 26'd4, 2'd1, 32'h0);
    check("t3_lbu_const", dado_lido, 32'h000000F0);
    run_req("t3_lh", 1'b0, 2'd1, 1'b1, 26'd4, 2'd2, 32'h0);
    check("t3_lh_const", dado_lido, 32'hFFFF8000);

    // 4: error cases
    run_req("t4_lw_mis", 1'b0, 2'd2, 1'b0, 26'd4, 2'd2, 32'h0);
    run_req("t4_sh_mis", 1'b1, 2'd1, 1'b0, 26'd4, 2'd3, 32'h12345678);
    run_req("t4_resv", 1'b1, 2'd3, 1'b0, 26'd4, 2'd0, 32'h12345678);
    run_req("t4_range", 1'b0, 2'd2, 1'b0, 26'd150, 2'd0, 32'h0);
    run_req("t4_range_sw", 1'b1, 2'd2, 1'b0, 26'd150, 2'd0, 32'h55555555);

    // 5: request held high with a changed address while busy
    w0 = wr_total;
    req_valid = 1'b1; req_escrita = 1'b1; req_tamanho = 2'd2; req_sinal = 1'b0;
    req_endereco = 28'h20; req_dado = 32'hCAFE0001;
    @(posedge clock);
    @(negedge clock);
    req_endereco = 28'h24; req_dado = 32'hCAFE0002;
    wait_pronto(lat);
    check("t5_lat1", 32'(lat), 32'd2);
    check("t5_mem8", mem[8], 32'hCAFE0001);
    check("t5_mem9_intacto", mem[9], ref_mem[9]);
    ref_mem[8] = 32'hCAFE0001;
    @(negedge clock);
    check("t5_ocioso", {31'd0, ocupado}, 32'd0);
    check("t5_escritas1", 32'(wr_total - w0), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("t5_ocupado2", {31'd0, ocupado}, 32'd1);
    wait_pronto(lat);
    check("t5_lat2", 32'(lat), 32'd2);
    ref_mem[9] = 32'hCAFE0002;
    @(negedge clock);
    check("t5_mem9", mem[9], 32'hCAFE0002);

    // 6: reset during the write cycle of a byte store
    w0 = wr_total;
    req_valid = 1'b1; req_escrita = 1'b1; req_tamanho = 2'd0; req_sinal = 1'b0;
    req_endereco = 28'h11; req_dado = 32'h00000055;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("t6_we_escrever", {31'd0, mem_memWrite}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_saidas", {28'd0, pronto, ocupado, erro, mem_memWrite}, 32'd0);
    check("t6_dado_lido", dado_lido, 32'h0);
    check("t6_mem_end", 32'(mem_endereco), 32'h0);
    check("t6_mem_dado", mem_dado_escrito, 32'h0);
    check("t6_mem4", mem[4], 32'h8000F0FF);
    check("t6_escritas", 32'(wr_total - w0), 32'd0);
    reset = 1'b0;
    exp_dl = 32'h0;
    @(negedge clock);
    run_req("t6_lw", 1'b0, 2'd2, 1'b0, 26'd4, 2'd0, 32'h0);

    // Random requests against the reference model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    tam = 2'd0;
        2, 3:    tam = 2'd1;
        7:       tam = 2'd3;
        default: tam = 2'd2;
      endcase
      off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (tam == 2'd1)      off = off & 2'b10;
        else if (tam == 2'd2) off = 2'b00;
        else                  off = off;
      end
      word = 26'($urandom_range(0, 155));
      if ($urandom_range(0, 2) != 0) word = 26'($urandom_range(0, 11));
      run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), tam,
              1'($urandom_range(0, 1)), word, off, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
